// File: rtl/icache_refill.sv
// icache_refill: fetches a missed instruction block beat by beat and writes it into the L1 icache.
// Optional watchdog: define ICACHE_REFILL_TIMEOUT_EN to abort a refill that waits too long for gnt or rvalid.
module icache_refill #(
    parameter int ADDR_W  = 32,
    parameter int BEAT_W  = 32,
    parameter int BLOCK_W = 64,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               miss_i,
    input  logic [ADDR_W-1:0]  miss_addr_i,
    output logic               busy_o,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [BEAT_W-1:0]  mem_rdata_i,
    output logic               ic_we_o,
    output logic [ADDR_W-1:0]  ic_addr_o,
    output logic [BLOCK_W-1:0] ic_block_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int BEATS       = BLOCK_W / BEAT_W;
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BLOCK_BYTES = BLOCK_W / 8;

    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BLOCK_BYTES - 1));
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    // Reject geometries the beat slicing and address stepping cannot handle.
    if (BEATS < 1 || (BEATS & (BEATS - 1)) != 0 || BLOCK_W != BEATS * BEAT_W) begin : g_bad_geometry
        $error("icache_refill: BLOCK_W must be a power-of-two multiple of BEAT_W");
    end
    if (BEAT_W % 8 != 0) begin : g_bad_beat
        $error("icache_refill: BEAT_W must be a whole number of bytes");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("icache_refill: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat;
    logic [BLOCK_W-1:0] block;
    logic [BLOCK_W-1:0] merged;
    logic [ADDR_W-1:0]  base;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wdog;
`endif

    // Block with the incoming beat dropped into its slot, beat 0 in the LSBs.
    always_comb begin
        merged = block;
        merged[int'(beat) * BEAT_W +: BEAT_W] = mem_rdata_i;
    end

    // Refill FSM; every output is a registered decode of the state transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            beat       <= '0;
            block      <= '0;
            base       <= '0;
            busy_o     <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            ic_we_o    <= 1'b0;
            ic_addr_o  <= '0;
            ic_block_o <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
            wdog       <= '0;
`endif
        end else begin
            ic_we_o <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (miss_i) begin
                        base       <= miss_addr_i & ALIGN_MASK;
                        mem_addr_o <= miss_addr_i & ALIGN_MASK;
                        mem_req_o  <= 1'b1;
                        busy_o     <= 1'b1;
                        beat       <= '0;
                        block      <= '0;
                        state      <= REQ;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wdog       <= '0;
`endif
                    end
                end

                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= WAIT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wdog      <= '0;
`endif
                    end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    else if (wdog == WD_LAST) begin
                        mem_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        block     <= '0;
                        state     <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
`endif
                end

                WAIT: begin
                    if (mem_rvalid_i) begin
                        block <= merged;
                        if (beat == LAST_BEAT) begin
                            ic_we_o    <= 1'b1;
                            done_o     <= 1'b1;
                            ic_addr_o  <= base;
                            ic_block_o <= merged;
                            state      <= WRITE;
                        end else begin
                            beat       <= beat + CNT_W'(1);
                            mem_addr_o <= mem_addr_o + BEAT_BYTES;
                            mem_req_o  <= 1'b1;
                            state      <= REQ;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                            wdog       <= '0;
`endif
                        end
                    end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    else if (wdog == WD_LAST) begin
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        block  <= '0;
                        state  <= IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
`endif
                end

                WRITE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_o    <= 1'b0;
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed refill scenarios with a scoreboard of expected icache writes.
// The watchdog scenario runs only when ICACHE_REFILL_TIMEOUT_EN is defined.
module tb_icache_refill;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        miss_i;
    logic [31:0] miss_addr_i;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        ic_we_o;
    logic [31:0] ic_addr_o;
    logic [63:0] ic_block_o;
    logic        done_o;
    logic        err_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] blk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    icache_refill #(
        .ADDR_W (32),
        .BEAT_W (32),
        .BLOCK_W(64),
        .TIMEOUT(64)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .miss_i      (miss_i),
        .miss_addr_i (miss_addr_i),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .ic_we_o     (ic_we_o),
        .ic_addr_o   (ic_addr_o),
        .ic_block_o  (ic_block_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_i);
    endtask

    // Every icache write must match the oldest expected block.
    always @(negedge clk_i) begin
        if (ic_we_o === 1'b1) begin
            check("we_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("sb_addr", 64'(ic_addr_o), 64'(e.addr));
                check("sb_block", ic_block_o, e.blk);
            end
        end
    end

    // One refill with a cooperative memory; cycle 1 is the miss cycle.
    task automatic refill(input logic [31:0] addr, input logic [31:0] d0,
                          input logic [31:0] d1, input int gdly, input int lat,
                          input bit busy_miss);
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] d[2];
        int          cyc;
        base = addr & ~32'h7;
        d[0] = d0;
        d[1] = d1;
        q.push_back('{base, {d1, d0}});
        miss_i      = 1'b1;
        miss_addr_i = addr;
        cyc = 1;
        tick;
        cyc++;
        miss_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            a = base + 32'(b * 4);
            if (b == 0) begin
                for (int w = 0; w < gdly; w++) begin
                    check("req_hold", 64'(mem_req_o), 64'd1);
                    check("addr_hold", 64'(mem_addr_o), 64'(a));
                    tick;
                    cyc++;
                end
            end
            check("req", 64'(mem_req_o), 64'd1);
            check("beat_addr", 64'(mem_addr_o), 64'(a));
            mem_gnt_i = 1'b1;
            tick;
            cyc++;
            mem_gnt_i = 1'b0;
            check("req_drop", 64'(mem_req_o), 64'd0);
            check("busy", 64'(busy_o), 64'd1);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = d[b];
            if (busy_miss && b == 0) begin
                miss_i      = 1'b1;
                miss_addr_i = 32'h0000_0200;
            end
            tick;
            cyc++;
            mem_rvalid_i = 1'b0;
            miss_i       = 1'b0;
        end
        check("we", 64'(ic_we_o), 64'd1);
        check("done", 64'(done_o), 64'd1);
        check("latency", 64'(cyc), 64'(lat));
        check("no_err", 64'(err_o), 64'd0);
        tick;
        check("we_pulse", 64'(ic_we_o), 64'd0);
        check("done_pulse", 64'(done_o), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
        check("blk_hold", ic_block_o, {d1, d0});
        check("addr_hold_ic", 64'(ic_addr_o), 64'(base));
    endtask

    initial begin
        rst_i        = 1'b1;
        miss_i       = 1'b0;
        miss_addr_i  = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        tick;
        tick;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_req", 64'(mem_req_o), 64'd0);
        check("rst_we", 64'(ic_we_o), 64'd0);
        check("rst_block", ic_block_o, 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst_i = 1'b0;
        tick;

        // zero-wait refill, PC inside the block
        refill(32'h0000_0104, 32'h1111_1111, 32'h2222_2222, 0, 6, 1'b0);

        // grant held off three cycles on beat 0
        refill(32'h0000_0100, 32'h3333_3333, 32'h4444_4444, 3, 9, 1'b0);

        // miss to 0x200 while the 0x100 refill is in WAIT
        refill(32'h0000_0100, 32'h5555_5555, 32'h6666_6666, 0, 6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("no_second_req", 64'(mem_req_o), 64'd0);
            check("no_second_busy", 64'(busy_o), 64'd0);
            tick;
        end

        // reset during WAIT of beat 1
        miss_i      = 1'b1;
        miss_addr_i = 32'h0000_0100;
        tick;
        miss_i    = 1'b0;
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hAAAA_AAAA;
        tick;
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        tick;
        mem_gnt_i = 1'b0;
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        #1 rst_i = 1'b1;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_req", 64'(mem_req_o), 64'd0);
        check("arst_maddr", 64'(mem_addr_o), 64'd0);
        check("arst_we", 64'(ic_we_o), 64'd0);
        check("arst_iaddr", 64'(ic_addr_o), 64'd0);
        check("arst_block", ic_block_o, 64'd0);
        check("arst_done", 64'(done_o), 64'd0);
        tick;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBBBB_BBBB;
        tick;
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("post_rst_idle", 64'(busy_o), 64'd0);
            check("post_rst_we", 64'(ic_we_o), 64'd0);
        end
        refill(32'h0000_0300, 32'h7777_7777, 32'h8888_8888, 0, 6, 1'b0);

        // top of the address space
        refill(32'hFFFF_FFFC, 32'h9999_9999, 32'hCCCC_CCCC, 0, 6, 1'b0);

`ifdef ICACHE_REFILL_TIMEOUT_EN
        begin
            int n;
            bit seen;
            miss_i      = 1'b1;
            miss_addr_i = 32'h0000_0400;
            tick;
            miss_i    = 1'b0;
            mem_gnt_i = 1'b1;
            tick;
            mem_gnt_i = 1'b0;
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 200) begin
                tick;
                n++;
                if (err_o === 1'b1) seen = 1'b1;
            end
            check("wd_seen", 64'(seen), 64'd1);
            check("wd_cycles", 64'(n), 64'd64);
            check("wd_no_we", 64'(ic_we_o), 64'd0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            tick;
            mem_rvalid_i = 1'b0;
            check("wd_err_pulse", 64'(err_o), 64'd0);
            check("wd_busy", 64'(busy_o), 64'd0);
            tick;
            check("wd_late_rvalid", 64'(busy_o), 64'd0);
            refill(32'h0000_0408, 32'h0101_0101, 32'h0202_0202, 0, 6, 1'b0);
        end
`endif

        tick;
        check("sb_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=stalled expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Write-side companion to the L1 instruction cache.
- On an icache miss it fetches the block-aligned instruction block from backing memory, one beat per request/response handshake.
- It assembles the beats and drives the icache write port (we, address, block) for one cycle, so fetch can retry and hit.
- Sits between the icache miss signal and the memory interface.

Parameters:
- ADDR_W, 32, address width (matches ADDR_SIZE).
- BEAT_W, 32, memory data width per beat.
- BLOCK_W, 64, icache block width; BEATS = BLOCK_W/BEAT_W (2 by default, must be a power of two ≥1).
- TIMEOUT, 64, cycles allowed per beat response when the watchdog is compiled in.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active high.
- miss_i  in  1  icache miss request (fetch valid and not hit).
- miss_addr_i  in  ADDR_W  PC that missed.
- busy_o  out  1  refill in progress.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  ADDR_W  beat byte address.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  BEAT_W  read data.
- ic_we_o  out  1  icache write enable, single-cycle pulse.
- ic_addr_o  out  ADDR_W  block-aligned write address.
- ic_block_o  out  BLOCK_W  assembled block.
- done_o  out  1  refill complete, single-cycle pulse, same cycle as ic_we_o.
- err_o  out  1  refill aborted, single-cycle pulse.

Behaviour:
- Reset (async, active high): state IDLE. All outputs 0. Beat counter 0, block register 0.
- BLOCK_BYTES = BLOCK_W/8. base = miss_addr_i with the low log2(BLOCK_BYTES) bits cleared; base is captured on entry to REQ.
- IDLE:
  - busy_o=0.
  - If miss_i=1: capture base, beat=0, go to REQ next cycle.
- REQ:
  - mem_req_o=1, mem_addr_o = base + beat*(BEAT_W/8), busy_o=1.
  - Request and address are held stable until mem_gnt_i=1.
  - On gnt: go to WAIT.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i=1: store rdata into block bits [beat*BEAT_W +: BEAT_W] (beat 0 in the LSBs).
  - If beat == BEATS-1, go to WRITE; else beat++ and go to REQ.
- WRITE (1 cycle):
  - ic_we_o=1, ic_addr_o=base, ic_block_o=block, done_o=1.
  - Next state IDLE.
- Outputs are registered state decodes. Latency from miss_i to ic_we_o with zero-wait memory (gnt in REQ cycle, rvalid the next cycle) is 1 + 2*BEATS + 1 cycles: 6 cycles for BEATS=2.
- Protocol rules:
  - rvalid is only legal at least one cycle after its gnt, with at most one outstanding beat.
  - rvalid outside WAIT is ignored.
  - gnt outside REQ is ignored.
- miss_i while busy: ignored, no queuing. Fetch keeps missing until the write lands, then re-asserts if still needed.
- miss_i in the WRITE cycle: ignored. It is accepted from IDLE on the following cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap at the top of the address space is allowed.
- ic_block_o holds its last value when ic_we_o=0. ic_addr_o and mem_addr_o hold their last value.
- Reset mid-refill aborts immediately: no ic_we_o, no done_o, block cleared.

Optional Feature:
- Macro: ICACHE_REFILL_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on entry to REQ or WAIT.
  - If it reaches TIMEOUT while waiting for gnt (REQ) or rvalid (WAIT), err_o pulses for 1 cycle and the FSM returns to IDLE. ic_we_o is not asserted and the partial block is discarded.
  - A late rvalid arriving in IDLE is ignored.
- Not defined: no counter; the FSM waits indefinitely and err_o is tied to 0.

Test Plan:
- Zero-wait refill: miss_addr_i=0x0000_0104, gnt same cycle, rdata beats 0x1111_1111 then 0x2222_2222 -> mem_addr_o 0x100 then 0x104; ic_we_o/done_o at cycle 6 with ic_addr_o=0x100 and ic_block_o=0x2222_2222_1111_1111.
- Backpressure: gnt delayed 3 cycles on beat 0 -> mem_req_o and mem_addr_o=0x100 held stable all 4 cycles; total latency 9 cycles.
- Miss while busy: pulse miss_i with addr 0x200 during the WAIT of a refill to 0x100 -> only the 0x100 block is written; no second refill starts.
- Async reset mid-refill: assert rst_i in WAIT of beat 1 -> all outputs 0 immediately; no ic_we_o after release; a new miss to 0x300 then refills correctly.
- Wrap: miss_addr_i=0xFFFF_FFFC -> beat addresses 0xFFFF_FFF8 and 0xFFFF_FFFC; ic_addr_o=0xFFFF_FFF8.
- With ICACHE_REFILL_TIMEOUT_EN, TIMEOUT=64: no rvalid after gnt -> err_o pulse exactly 64 cycles after entering WAIT; busy_o=0 the next cycle; ic_we_o never asserted.
